// File: rtl/rv_mem_loader_pkg.sv
// Shared types for the unified memory + loader: FSM encoding, byte-lane constants, addressing helper.
// Pure declarations; no latency or backpressure of its own.
package rv_mem_loader_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_SEL_W     = $clog2(BYTES_PER_WORD);

  // Byte address to word address; callers keep only the low AWIDTH bits, so upper bits alias.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr >> BYTE_SEL_W;
  endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Word RAM, one synchronous write port and two combinational read ports.
// Reads are zero-latency and see the pre-write value in the write cycle; never stalls.
module rv_mem_array #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DWIDTH-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DWIDTH-1:0] rdata_b
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/rv_mem_loader.sv
// Unified I/D memory with a byte-stream loader holding the core in reset until the image is in; 0-cycle reads, 1-word writes.
// Loader accepts a byte every cycle while loading (ld_ready); optional ld_csum output under RV_MEM_LOAD_CSUM_EN.
module rv_mem_loader
  import rv_mem_loader_pkg::*;
#(
  parameter int DPWIDTH  = 32,
  parameter int MEMDEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DPWIDTH-1:0] imem_addr,
  output logic [DPWIDTH-1:0] imem_data,
  input  logic [DPWIDTH-1:0] dmem_addr,
  input  logic [DPWIDTH-1:0] dmem_wdata,
  input  logic               memrw,
  output logic [DPWIDTH-1:0] dmem_rdata,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               core_rst,
  output logic               ld_done,
  output logic               ld_err
`ifdef RV_MEM_LOAD_CSUM_EN
  ,
  output logic [7:0]         ld_csum
`endif
);

  localparam int AWIDTH = $clog2(MEMDEPTH);

  state_t              state, state_nxt;
  logic [AWIDTH:0]     ptr;
  logic [1:0]          bcnt;
  logic [23:0]         asm_q;
  logic                accept;
  logic                full;
  logic                ld_we;
  logic [31:0]         ld_word;
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [DPWIDTH-1:0]  mem_wdata;
  logic [31:0]         iwa, dwa;
  logic                unused_hi;

  assign iwa       = word_addr(imem_addr);
  assign dwa       = word_addr(dmem_addr);
  assign unused_hi = ^{iwa[31:AWIDTH], dwa[31:AWIDTH]};

  assign accept = ld_valid && (state == LOAD);
  // Pointer only ever reaches MEMDEPTH, so its top bit alone flags "memory full".
  assign full   = ptr[AWIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    core_rst  = 1'b0;
    ld_done   = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (accept && ld_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        core_rst = 1'b1;
        ld_done  = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Little-endian assembly; lanes not yet received read as zero so a short final word pads with zeros.
  always_comb begin
    ld_word = '0;
    case (bcnt)
      2'd0:    ld_word = {24'h0, ld_byte};
      2'd1:    ld_word = {16'h0, ld_byte, asm_q[7:0]};
      2'd2:    ld_word = {8'h0, ld_byte, asm_q[15:0]};
      default: ld_word = {ld_byte, asm_q};
    endcase
  end

  assign ld_we = accept && !full && ((bcnt == 2'd3) || ld_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      bcnt   <= '0;
      asm_q  <= '0;
      ld_err <= 1'b0;
    end else if (accept) begin
      if (full) begin
        ld_err <= 1'b1;
      end else if (ld_we) begin
        ptr   <= ptr + 1'b1;
        bcnt  <= '0;
        asm_q <= '0;
      end else begin
        asm_q <= ld_word[23:0];
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

`ifdef RV_MEM_LOAD_CSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_csum <= '0;
    end else if (accept) begin
      ld_csum <= ld_csum + ld_byte;
    end
  end
`endif

  always_comb begin
    if (state == LOAD) begin
      mem_we    = ld_we;
      mem_waddr = ptr[AWIDTH-1:0];
      mem_wdata = ld_word;
    end else begin
      mem_we    = memrw;
      mem_waddr = dwa[AWIDTH-1:0];
      mem_wdata = dmem_wdata;
    end
  end

  rv_mem_array #(
    .DWIDTH (DPWIDTH),
    .DEPTH  (MEMDEPTH),
    .AW     (AWIDTH)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (iwa[AWIDTH-1:0]),
    .rdata_a (imem_data),
    .raddr_b (dwa[AWIDTH-1:0]),
    .rdata_b (dmem_rdata)
  );

endmodule

// File: tb/tb_rv_mem_loader.sv
// Scoreboard bench: a 1024-word instance for load/run/alias/reset cases and a 4-word instance for overflow.
module tb_rv_mem_loader;

  logic        clk;
  logic        rst;

  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic [31:0] imem_data, dmem_rdata;
  logic        memrw, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ld_ready, core_rst, ld_done, ld_err;
`ifdef RV_MEM_LOAD_CSUM_EN
  logic [7:0]  ld_csum;
  logic [7:0]  sm_ld_csum;
`endif

  logic [31:0] sm_imem_addr, sm_dmem_addr, sm_dmem_wdata;
  logic [31:0] sm_imem_data, sm_dmem_rdata;
  logic        sm_memrw, sm_ld_valid, sm_ld_last;
  logic [7:0]  sm_ld_byte;
  logic        sm_ld_ready, sm_core_rst, sm_ld_done, sm_ld_err;

  rv_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .memrw      (memrw),
    .dmem_rdata (dmem_rdata),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .core_rst   (core_rst),
    .ld_done    (ld_done),
    .ld_err     (ld_err)
`ifdef RV_MEM_LOAD_CSUM_EN
    ,
    .ld_csum    (ld_csum)
`endif
  );

  rv_mem_loader #(.MEMDEPTH(4)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (sm_imem_addr),
    .imem_data  (sm_imem_data),
    .dmem_addr  (sm_dmem_addr),
    .dmem_wdata (sm_dmem_wdata),
    .memrw      (sm_memrw),
    .dmem_rdata (sm_dmem_rdata),
    .ld_valid   (sm_ld_valid),
    .ld_byte    (sm_ld_byte),
    .ld_last    (sm_ld_last),
    .ld_ready   (sm_ld_ready),
    .core_rst   (sm_core_rst),
    .ld_done    (sm_ld_done),
    .ld_err     (sm_ld_err)
`ifdef RV_MEM_LOAD_CSUM_EN
    ,
    .ld_csum    (sm_ld_csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  int          m_ptr   [2];
  int          m_cnt   [2];
  logic [31:0] m_word  [2];
  logic        m_err   [2];
  int          m_depth [2] = '{1024, 4};
  logic [7:0]  t1      [6] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ptr[s]  = 0;
      m_cnt[s]  = 0;
      m_word[s] = '0;
      m_err[s]  = 1'b0;
    end
  endtask

  // Reference loader: pushes each completed (or final partial) word to the scoreboard.
  task automatic model_byte(input bit sel, input logic [7:0] b, input logic last);
    if (m_ptr[sel] < m_depth[sel]) begin
      m_word[sel] = m_word[sel] | (32'(b) << (8 * m_cnt[sel]));
      m_cnt[sel]++;
      if (m_cnt[sel] == 4 || last) begin
        exp_q.push_back('{sel, 32'(m_ptr[sel] * 4), m_word[sel]});
        m_ptr[sel]++;
        m_cnt[sel]  = 0;
        m_word[sel] = '0;
      end
    end else begin
      m_err[sel] = 1'b1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the byte.
  task automatic send(input bit sel, input logic [7:0] b, input logic last);
    if (!sel) begin
      ld_valid = 1'b1; ld_byte = b; ld_last = last;
    end else begin
      sm_ld_valid = 1'b1; sm_ld_byte = b; sm_ld_last = last;
    end
    #1;
    check(sel ? "sm_ld_ready" : "ld_ready", sel ? sm_ld_ready : ld_ready, 1);
    model_byte(sel, b, last);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
    sm_ld_valid = 1'b0; sm_ld_last = 1'b0;
    check(sel ? "sm_ld_err" : "ld_err", sel ? sm_ld_err : ld_err, m_err[sel]);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (!e.sel) begin
        dmem_addr = e.addr; #1;
        check($sformatf("mem[%0h]", e.addr), dmem_rdata, e.data);
      end else begin
        sm_dmem_addr = e.addr; #1;
        check($sformatf("sm_mem[%0h]", e.addr), sm_dmem_rdata, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; memrw = 1'b0;
    ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    sm_imem_addr = '0; sm_dmem_addr = '0; sm_dmem_wdata = '0; sm_memrw = 1'b0;
    sm_ld_valid = 1'b0; sm_ld_byte = '0; sm_ld_last = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst core_rst", core_rst, 0);
    check("rst ld_ready", ld_ready, 1);
    check("rst ld_done", ld_done, 0);
    check("rst ld_err", ld_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic image with a trailing partial word
    for (int i = 0; i < 6; i++) begin
      send(0, t1[i], i == 5);
      if (i == 4) check("core_rst before last", core_rst, 0);
    end
    check("run core_rst", core_rst, 1);
    check("run ld_done", ld_done, 1);
    check("run ld_ready", ld_ready, 0);
    drain();

    // Reset mid-load, then reload with a stall inside the word
    do_reset();
    for (int i = 0; i < 6; i++) send(0, 8'(8'h11 * (i + 1)), 1'b0);
    drain();
    rst = 1'b0;
    model_reset();
    #3;
    check("midrst core_rst", core_rst, 0);
    check("midrst ld_err", ld_err, 0);
    check("midrst ld_ready", ld_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(0, 8'hA1, 1'b0);
    send(0, 8'hB2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    dmem_addr = 32'h0; #1;
    check("stall no write", dmem_rdata, 32'h44332211);
    @(posedge clk); #1;
    send(0, 8'hC3, 1'b0);
    dmem_addr = 32'h0; #1;
    check("3rd byte no write", dmem_rdata, 32'h44332211);
    @(posedge clk); #1;
    send(0, 8'hD4, 1'b1);
    exp_q.push_back('{1'b0, 32'h4, 32'h00000093});
    drain();
    check("reload ld_done", ld_done, 1);

    // RUN: core-side writes, old-value read in the write cycle, aliasing
    memrw = 1'b1; dmem_addr = 32'h1000; dmem_wdata = 32'hCAFEF00D; #1;
    check("read old in write cycle", dmem_rdata, 32'hD4C3B2A1);
    @(posedge clk); #1;
    memrw = 1'b0; imem_addr = 32'h0; #1;
    check("imem after alias write", imem_data, 32'hCAFEF00D);
    @(posedge clk); #1;
    memrw = 1'b1; dmem_addr = 32'h8; dmem_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    memrw = 1'b0; #1;
    check("dmem_rdata after store", dmem_rdata, 32'hDEADBEEF);
    imem_addr = 32'h1008; #1;
    check("imem alias 0x1008", imem_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_byte = 8'h55; ld_last = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0; dmem_addr = 32'h4; #1;
    check("run ignores loader", dmem_rdata, 32'h00000093);
    check("run ld_ready stays 0", ld_ready, 0);
    check("run core_rst stays 1", core_rst, 1);
    @(posedge clk); #1;

    // Overflow on the 4-word instance
    do_reset();
    for (int i = 1; i <= 20; i++) send(1, 8'(i), i == 20);
    check("sm ld_done", sm_ld_done, 1);
    check("sm ld_err sticky", sm_ld_err, 1);
    drain();

`ifdef RV_MEM_LOAD_CSUM_EN
    do_reset();
    check("csum reset", ld_csum, 0);
    send(0, 8'hFF, 1'b0);
    send(0, 8'h02, 1'b1);
    check("ld_csum", ld_csum, 8'h01);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
